// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: several producers share one FIFO write port.
// A producer owns the port for a burst of words, then the pointer advances.
// Optional feature macro: FIFO_ARB_BURST_EN. When defined, a grant lasts up to
// MAX_BURST words; when undefined, the grant is released after every word and
// no burst counter is built.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no owner; pick the next requester searching upward from rr_ptr
// ST_OWN  | producer g owns the FIFO port; words move when req[g] & !full
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_w_en,
  output logic [DATA_W-1:0]         o_fifo_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..16");
  end

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   g_next_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               xfer;
  logic               last_word;
  logic [NUM_REQ-1:0] g_onehot;

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last_word = (cnt_q == CNT_W'(MAX_BURST - 1));
`else
  assign last_word = 1'b1;
`endif

  assign g_onehot   = NUM_REQ'(1) << g_q;
  assign g_next_ptr = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
  assign xfer       = (state_q == ST_OWN) && i_req[g_q] && !i_fifo_full;

  // Rotating priority search: first requester at or above rr_ptr, with wrap.
  always_comb begin
    int k;
    k          = 0;
    pick_idx   = rr_ptr_q;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!pick_found && i_req[k[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = k[IDX_W-1:0];
      end
    end
  end

  // State, owner, pointer and (optionally) burst count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      rr_ptr_q <= '0;
`ifdef FIFO_ARB_BURST_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state logic and outputs; outputs fall to zero as soon as reset
  // forces the state register back to idle.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d       = cnt_q;
`endif
    o_busy      = 1'b0;
    o_grant     = '0;
    o_ack       = '0;
    o_fifo_w_en = 1'b0;
    o_fifo_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          g_d     = pick_idx;
          state_d = ST_OWN;
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_OWN: begin
        o_busy      = 1'b1;
        o_grant     = g_onehot;
        o_fifo_data = i_data[g_q*DATA_W +: DATA_W];
        if (xfer) begin
          o_ack       = g_onehot;
          o_fifo_w_en = 1'b1;
`ifdef FIFO_ARB_BURST_EN
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
        // Release when the owner stops requesting or its burst is used up.
        if (!i_req[g_q] || (xfer && last_word)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = g_next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DATA_W=8, NUM_REQ=4, MAX_BURST=4).
// Expected burst length follows FIFO_ARB_BURST_EN: 4 words when defined, else 1.
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
  localparam int LIMIT = 4;
`else
  localparam int LIMIT = 1;
`endif
  localparam int BP_PRE = (LIMIT >= 2) ? 2 : 0;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_req = 4'b0000;
  logic [31:0] i_data = 32'h44332211;
  logic        i_fifo_full = 1'b0;
  logic        o_fifo_w_en;
  logic [7:0]  o_fifo_data;
  logic [3:0]  o_ack;
  logic [3:0]  o_grant;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(.DATA_W(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .i_fifo_full(i_fifo_full),
    .o_fifo_w_en(o_fifo_w_en),
    .o_fifo_data(o_fifo_data),
    .o_ack      (o_ack),
    .o_grant    (o_grant),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] word(input int k);
    return 8'(8'h11 * (k + 1));
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic busy, input logic [3:0] grant,
                            input logic [3:0] ack, input logic wen, input logic [7:0] data);
    #1;
    chk({tag, "_busy"},  32'(o_busy),      32'(busy));
    chk({tag, "_grant"}, 32'(o_grant),     32'(grant));
    chk({tag, "_ack"},   32'(o_ack),       32'(ack));
    chk({tag, "_wen"},   32'(o_fifo_w_en), 32'(wen));
    chk({tag, "_data"},  32'(o_fifo_data), 32'(data));
  endtask

  task automatic expect_idle(input string tag);
    expect_out(tag, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
  endtask

  task automatic expect_own(input string tag, input int k, input logic moved);
    logic [3:0] oh;
    oh = 4'(1 << k);
    expect_out(tag, 1'b1, oh, moved ? oh : 4'b0000, moved, word(k));
  endtask

  // Hold reset for two cycles with the given requests, then release mid-cycle.
  task automatic do_reset(input string tag, input logic [3:0] req);
    i_rst_n = 1'b0;
    i_req = req;
    i_fifo_full = 1'b0;
    tick();
    expect_idle({tag, "_rst0"});
    tick();
    expect_idle({tag, "_rst1"});
    i_rst_n = 1'b1;
    expect_idle({tag, "_rel"});
  endtask

  // Requests held constant; seq holds the expected owner order, 2 bits each.
  task automatic run_rr(input string tag, input logic [3:0] req, input int n, input logic [15:0] seq);
    int k;
    do_reset(tag, req);
    for (int r = 0; r < n; r++) begin
      k = int'(seq[2*r +: 2]);
      for (int j = 0; j < LIMIT; j++) begin
        tick();
        expect_own($sformatf("%s_g%0d_w%0d", tag, r, j), k, 1'b1);
      end
      tick();
      expect_idle($sformatf("%s_gap%0d", tag, r));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with all requesting, first grant goes to producer 0.
    do_reset("reset", 4'b1111);
    tick();
    expect_own("first_grant", 0, 1'b1);
    // Reset asserted mid-burst clears outputs without a clock edge.
    i_rst_n = 1'b0;
    expect_idle("async_rst");

    // Single producer: burst, one idle cycle, regrant to the same producer.
    do_reset("single", 4'b0001);
    for (int j = 0; j < LIMIT; j++) begin
      tick();
      expect_own($sformatf("single_w%0d", j), 0, 1'b1);
    end
    tick();
    expect_idle("single_gap");
    tick();
    expect_own("single_regrant", 0, 1'b1);

    // All requesting: owners 0,1,2,3,0.
    run_rr("rr4", 4'b1111, 5, 16'h00E4);

    // Two requesters: owners alternate 0,1,0,1.
    run_rr("rr2", 4'b0011, 4, 16'h0044);

    // Backpressure: three full cycles hold grant and count.
    do_reset("bp", 4'b0001);
    for (int j = 0; j < BP_PRE; j++) begin
      tick();
      expect_own($sformatf("bp_pre%0d", j), 0, 1'b1);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      i_fifo_full = 1'b1;
      expect_own($sformatf("bp_full%0d", j), 0, 1'b0);
    end
    for (int j = 0; j < LIMIT - BP_PRE; j++) begin
      tick();
      i_fifo_full = 1'b0;
      expect_own($sformatf("bp_post%0d", j), 0, 1'b1);
    end
    tick();
    expect_idle("bp_gap");

    // Early release: producer 0 drops after one word; pointer moves to 1 even
    // though producer 0 requests again during the idle cycle.
    do_reset("early", 4'b0011);
    tick();
    expect_own("early_w0", 0, 1'b1);
`ifdef FIFO_ARB_BURST_EN
    tick();
    i_req = 4'b0010;
    expect_own("early_drop", 0, 1'b0);
    tick();
    i_req = 4'b0011;
    expect_idle("early_gap");
    tick();
    expect_own("early_next", 1, 1'b1);
`else
    tick();
    i_req = 4'b0010;
    expect_idle("early_gap");
    tick();
    i_req = 4'b0011;
    expect_own("early_next", 1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of each data word.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of producers, legal range 2..8.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum words per grant, legal range 1..16.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_req, input, NUM_REQ bits: bit k high means producer k holds a word.
REQ-007 The block SHALL have port i_data, input, NUM_REQ*DATA_W bits: producer k's word at [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have port i_fifo_full, input, 1 bit: the FIFO full flag.
REQ-009 The block SHALL have port o_fifo_w_en, output, 1 bit: FIFO write enable.
REQ-010 The block SHALL have port o_fifo_data, output, DATA_W bits: FIFO write data.
REQ-011 The block SHALL have port o_ack, output, NUM_REQ bits: one-hot; bit k high means producer k's word is accepted this cycle.
REQ-012 The block SHALL have port o_grant, output, NUM_REQ bits: one-hot current owner, or all zero.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high while in state OWN.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (no owner) and OWN (one owner g).
REQ-015 In IDLE with i_req non-zero, the block SHALL pick the first set bit searching upward from rr_ptr with wrap, load g, clear the burst count, and enter OWN on the next edge.
REQ-016 In IDLE, o_grant, o_ack and o_fifo_w_en SHALL be all zero.
REQ-017 In OWN, a transfer SHALL occur in any cycle where i_req[g]=1 and i_fifo_full=0.
REQ-018 o_fifo_w_en and o_ack[g] SHALL be high combinationally in exactly the transfer cycles.
REQ-019 o_fifo_data SHALL equal producer g's word while in OWN and SHALL be zero in IDLE.
REQ-020 The burst count SHALL increment by 1 per transfer.
REQ-021 OWN SHALL be released to IDLE on the next edge after the transfer that brings the count to the effective burst limit.
REQ-022 OWN SHALL also be released to IDLE on the next edge after a cycle in which i_req[g]=0.
REQ-023 On every release, rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-024 A release costs exactly one IDLE cycle before the next grant.
REQ-025 While i_fifo_full=1 in OWN, the block SHALL make no transfer, hold the grant and hold the count, with no timeout.
REQ-026 Requests from producers other than g SHALL be ignored during OWN; no producer SHALL receive o_ack while not granted.
REQ-027 No more than one word SHALL be written per cycle.
REQ-028 The block SHALL never assert o_fifo_w_en while i_fifo_full=1.

Reset
REQ-029 While i_rst_n=0, the block SHALL be in state IDLE with rr_ptr=0, count=0 and g=0.
REQ-030 While i_rst_n=0, o_grant, o_ack, o_busy, o_fifo_w_en and o_fifo_data SHALL all be 0.
REQ-031 Assertion of reset mid-burst SHALL drop o_fifo_w_en immediately, without waiting for a clock edge.
REQ-032 After reset deasserts, arbitration SHALL restart from producer 0.

Configuration
REQ-033 With macro FIFO_ARB_BURST_EN defined, the effective burst limit SHALL be MAX_BURST.
REQ-034 With FIFO_ARB_BURST_EN undefined, the effective burst limit SHALL be 1, so the grant is released after every word.
REQ-035 With FIFO_ARB_BURST_EN undefined, the burst counter SHALL be omitted; all other behaviour is unchanged.

Verification
REQ-036 Reset: i_rst_n=0 with i_req=4'b1111 -> all outputs 0; after release, first grant is 4'b0001.
REQ-037 Single producer, macro on: i_req=4'b0001, word0=8'h11, full=0 -> grant one cycle later, 4 consecutive writes of 8'h11, one IDLE cycle, then regrant.
REQ-038 Round-robin: i_req=4'b1111 held, macro on -> grants 0,1,2,3,0 in order, 4 words each, one IDLE cycle between grants.
REQ-039 Backpressure: i_fifo_full=1 for 3 cycles after 2 words of grant 0 -> w_en and ack 0 during those cycles, grant held, then exactly 2 more words.
REQ-040 Early release: i_req[0] drops after 1 word with i_req[1]=1 -> IDLE for 1 cycle, rr_ptr=1, grant 4'b0010.
REQ-041 Macro off: i_req=4'b0011 held -> grants alternate 0,1,0,1 with one word each.
